mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch requester and the load/store requester of the RV32 core.
- Sits between the core (PC/fetch path and data-memory path) and the memory macro.
- Arbitrates with data-over-fetch priority plus a starvation guard.
- Sequences each memory access as request, grant, response, with exactly one transaction outstanding at a time.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/arb_prio_select.sv | 27 ++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 614 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and width constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int ARB_DATA_W = 32;
  localparam int ARB_ADDR_W = 16;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  // Bit positions inside the grant vector returned by arb_prio_select.
  localparam int GNT_FETCH = 0;
  localparam int GNT_DATA  = 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  // One memory access as it is presented to the memory macro.
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  we;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/arb_prio_select.sv
// Data-over-fetch priority with a starvation override for fetch.
module arb_prio_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             if_valid,
  input  logic             d_valid,
  input  logic [CNT_W-1:0] cnt,
  output logic [1:0]       gnt
);

  logic starved;

  // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    gnt     = '0;
    starved = if_valid && (cnt == CNT_W'(STARVE_LIMIT));
    if (d_valid && !starved) begin
      gnt[GNT_DATA] = 1'b1;
    end else if (if_valid) begin
      gnt[GNT_FETCH] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One transaction outstanding at a time: IDLE accepts, REQ waits for the
// memory grant, RESP waits for the memory response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = ARB_DATA_W,
  parameter int ADDRESS_WIDTH = ARB_ADDR_W,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req_valid,
  output logic                      if_req_ready,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  output logic                      if_rvalid,
  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic [ADDRESS_WIDTH-1:0]  d_addr,
  input  logic                      d_we,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_be,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      d_rvalid,
  output logic                      mem_req,
  input  logic                      mem_gnt,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic                      mem_we,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      busy
);

  // Counter must be able to hold STARVE_LIMIT itself.
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  owner_t           owner;
  mem_req_t         req;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt;
  logic             accept_if;
  logic             accept_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(STARVE_LIMIT)) ? v : v + 1'b1;
  endfunction

  arb_prio_select #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_prio (
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .cnt      (cnt),
    .gnt      (gnt)
  );

  // Next-state logic; acceptance is only possible while idle.
  always_comb begin
    state_nxt = state;
    accept_if = 1'b0;
    accept_d  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt[GNT_DATA]) begin
          accept_d  = 1'b1;
          state_nxt = REQ;
        end else if (gnt[GNT_FETCH]) begin
          accept_if = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) state_nxt = RESP;
      end
      RESP: begin
        if (mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Readies are masked by reset so every output reads 0 while rst is low.
  always_comb begin
    if_req_ready = accept_if & rst;
    d_req_ready  = accept_d & rst;
    mem_req      = (state == REQ);
    busy         = (state != IDLE);
    mem_addr     = req.addr;
    mem_we       = req.we;
    mem_wdata    = req.wdata;
    mem_be       = req.be;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the accepted request; fetches are always full-word reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req   <= '0;
      owner <= OWN_FETCH;
    end else if (accept_d) begin
      req   <= '{addr: d_addr, we: d_we, wdata: d_wdata, be: d_be};
      owner <= OWN_DATA;
    end else if (accept_if) begin
      req   <= '{addr: if_addr, we: 1'b0, wdata: '0, be: '1};
      owner <= OWN_FETCH;
    end
  end

  // Count data grants that bypassed a waiting fetch; a fetch grant clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept_d && if_req_valid) begin
      cnt <= sat_inc(cnt);
    end else if (accept_if) begin
      cnt <= '0;
    end
  end

  // Route the memory response to its owner as a one-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (state == RESP && mem_rvalid) begin
        if (owner == OWN_DATA) begin
          d_rdata  <= mem_rdata;
          d_rvalid <= 1'b1;
        end else begin
          if_rdata  <= mem_rdata;
          if_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a memory responder model, an
// acceptance/response scoreboard and one task per scenario.
module tb_mem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req_valid, d_req_ready, d_we, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [BW-1:0] d_be;
  logic          mem_req, mem_gnt, mem_we, mem_rvalid, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_be;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_rvalid    (if_rvalid),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_addr       (d_addr),
    .d_we         (d_we),
    .d_wdata      (d_wdata),
    .d_be         (d_be),
    .d_rdata      (d_rdata),
    .d_rvalid     (d_rvalid),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  typedef struct {
    bit            is_data;
    logic [DW-1:0] rdata;
  } exp_rsp_t;

  typedef struct {
    bit            is_data;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } exp_mem_t;

  exp_rsp_t      rsp_q[$];
  exp_mem_t      mem_q[$];
  bit            acc_log[$];
  logic [AW-1:0] mem_addr_log[$];

  int n_cmp = 0;
  int n_bad = 0;
  int if_pulses = 0;
  int d_pulses = 0;
  int gnt_delay = 0;
  bit rsp_en = 1'b1;
  int spur_rv_req = 0, spur_rv_done = 0;
  int spur_gnt_req = 0, spur_gnt_done = 0;

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return {a ^ 16'hC3A5, a};
  endfunction

  // Memory side: grant after gnt_delay REQ cycles, respond in the first RESP cycle.
  task automatic responder();
    int wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst) begin
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt >= gnt_delay) mem_gnt = 1'b1;
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        if (busy && rsp_en) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_model(mem_addr);
        end
      end
      if (spur_rv_req != spur_rv_done) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        spur_rv_done++;
      end
      if (spur_gnt_req != spur_gnt_done) begin
        mem_gnt = 1'b1;
        spur_gnt_done++;
      end
    end
  endtask

  // Scoreboard: push on acceptance, pop on memory grant and on rvalid.
  task automatic monitor();
    exp_rsp_t er;
    exp_mem_t em;
    bit ok;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        rsp_q.delete();
        mem_q.delete();
      end else begin
        if (d_req_valid && d_req_ready) begin
          rsp_q.push_back('{is_data: 1'b1, rdata: mem_model(d_addr)});
          mem_q.push_back('{is_data: 1'b1, addr: d_addr, we: d_we, wdata: d_wdata, be: d_be});
          acc_log.push_back(1'b1);
        end
        if (if_req_valid && if_req_ready) begin
          rsp_q.push_back('{is_data: 1'b0, rdata: mem_model(if_addr)});
          mem_q.push_back('{is_data: 1'b0, addr: if_addr, we: 1'b0, wdata: '0, be: '1});
          acc_log.push_back(1'b0);
        end
        if (mem_req && mem_gnt) begin
          mem_addr_log.push_back(mem_addr);
          n_cmp++;
          if (mem_q.size() == 0) begin
            n_bad++;
            $display("FAIL mem_grant: unexpected grant addr=%h, required no grant", mem_addr);
          end else begin
            em = mem_q.pop_front();
            ok = (mem_addr === em.addr) && (mem_we === em.we) && (mem_be === em.be) &&
                 (!em.is_data || mem_wdata === em.wdata);
            if (!ok) begin
              n_bad++;
              $display("FAIL mem_fields: got addr=%h we=%b wdata=%h be=%b, required addr=%h we=%b wdata=%h be=%b",
                       mem_addr, mem_we, mem_wdata, mem_be, em.addr, em.we, em.wdata, em.be);
            end
          end
        end
        if (if_rvalid) if_pulses++;
        if (d_rvalid) d_pulses++;
        if (if_rvalid || d_rvalid) begin
          n_cmp++;
          if (rsp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rsp: unexpected pulse if_rvalid=%b d_rvalid=%b, required none", if_rvalid, d_rvalid);
          end else begin
            er = rsp_q.pop_front();
            ok = er.is_data ? (d_rvalid === 1'b1 && if_rvalid === 1'b0 && d_rdata === er.rdata)
                            : (if_rvalid === 1'b1 && d_rvalid === 1'b0 && if_rdata === er.rdata);
            if (!ok) begin
              n_bad++;
              $display("FAIL rsp: got if_rvalid=%b if_rdata=%h d_rvalid=%b d_rdata=%h, required data=%0d rdata=%h",
                       if_rvalid, if_rdata, d_rvalid, d_rdata, er.is_data, er.rdata);
            end
          end
        end
      end
    end
  endtask

  task automatic send_fetch(input logic [AW-1:0] a);
    bit got = 1'b0;
    @(negedge clk);
    if_req_valid = 1'b1;
    if_addr      = a;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (if_req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL fetch_accept: if_req_ready=0 after 100 cycles, required 1");
    end
    @(negedge clk);
    if_req_valid = 1'b0;
  endtask

  task automatic send_data(input logic [AW-1:0] a, input logic we,
                           input logic [DW-1:0] wd, input logic [BW-1:0] be);
    bit got = 1'b0;
    @(negedge clk);
    d_req_valid = 1'b1;
    d_addr      = a;
    d_we        = we;
    d_wdata     = wd;
    d_be        = be;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (d_req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL data_accept: d_req_ready=0 after 100 cycles, required 1");
    end
    @(negedge clk);
    d_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (!busy && rsp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL idle_timeout: busy=%b pending=%0d, required idle with none pending", busy, rsp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if ({if_req_ready, d_req_ready, if_rvalid, d_rvalid, mem_req, mem_we, busy} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {if_req_ready, d_req_ready, if_rvalid, d_rvalid, mem_req, mem_we, busy});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_be, if_rdata, d_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got addr=%h wdata=%h be=%b if_rdata=%h d_rdata=%h, required all 0",
               mem_addr, mem_wdata, mem_be, if_rdata, d_rdata);
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fetch_read();
    int d0 = d_pulses;
    @(negedge clk);
    if_req_valid = 1'b1;
    if_addr      = 16'h0010;
    #2;
    n_cmp++;
    if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_c0: got if_ready=%b d_ready=%b, required 1 0", if_req_ready, d_req_ready);
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    #2;
    n_cmp++;
    if ({mem_req, mem_addr, mem_we, mem_be} !== {1'b1, 16'h0010, 1'b0, 4'hF}) begin
      n_bad++;
      $display("FAIL fetch_c1: got req=%b addr=%h we=%b be=%b, required 1 0010 0 1111",
               mem_req, mem_addr, mem_we, mem_be);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (mem_req !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL fetch_c2: got mem_req=%b busy=%b, required 0 1", mem_req, busy);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_c3: got if_rvalid=%b if_rdata=%h d_rvalid=%b, required 1 deadbeef 0",
               if_rvalid, if_rdata, d_rvalid);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF || d_pulses != d0) begin
      n_bad++;
      $display("FAIL fetch_c4: got if_rvalid=%b if_rdata=%h d_pulses=%0d, required 0 deadbeef %0d",
               if_rvalid, if_rdata, d_pulses, d0);
    end
  endtask

  task automatic test_simultaneous();
    int  a0 = acc_log.size();
    int  m0 = mem_addr_log.size();
    bit  d_acc = 1'b0, f_acc = 1'b0;
    @(negedge clk);
    d_req_valid  = 1'b1;
    d_addr       = 16'h0100;
    d_we         = 1'b0;
    d_wdata      = '0;
    d_be         = '1;
    if_req_valid = 1'b1;
    if_addr      = 16'h0020;
    for (int i = 0; i < 60 && !(d_acc && f_acc); i++) begin
      #2;
      if (d_req_ready) d_acc = 1'b1;
      if (if_req_ready) begin
        f_acc = 1'b1;
        n_cmp++;
        if (d_rvalid !== 1'b1) begin
          n_bad++;
          $display("FAIL simul_fetch_slot: d_rvalid=%b at fetch acceptance, required 1", d_rvalid);
        end
      end
      @(negedge clk);
      if (d_acc) d_req_valid = 1'b0;
      if (f_acc) if_req_valid = 1'b0;
    end
    d_req_valid  = 1'b0;
    if_req_valid = 1'b0;
    wait_idle();
    n_cmp++;
    if (acc_log.size() < a0 + 2 || acc_log[a0] !== 1'b1 || acc_log[a0+1] !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_order: accepts=%0d, required data then fetch", acc_log.size() - a0);
    end
    n_cmp++;
    if (mem_addr_log.size() < m0 + 2 || mem_addr_log[m0] !== 16'h0100 || mem_addr_log[m0+1] !== 16'h0020) begin
      n_bad++;
      $display("FAIL simul_mem_order: grants=%0d, required 0100 then 0020", mem_addr_log.size() - m0);
    end
  endtask

  task automatic test_starvation();
    int a0 = acc_log.size();
    bit chk_zero = 1'b0;
    @(negedge clk);
    d_req_valid  = 1'b1;
    d_addr       = 16'h0300;
    d_we         = 1'b0;
    d_be         = '1;
    if_req_valid = 1'b1;
    if_addr      = 16'h0040;
    for (int i = 0; i < 300 && (acc_log.size() - a0) < 10; i++) begin
      #2;
      if (chk_zero) begin
        chk_zero = 1'b0;
        n_cmp++;
        if (dut.cnt !== 3'd0) begin
          n_bad++;
          $display("FAIL starve_cnt_clear: cnt=%0d after fetch, required 0", dut.cnt);
        end
      end
      if (if_req_ready) begin
        chk_zero = 1'b1;
        n_cmp++;
        if (dut.cnt !== 3'(LIMIT)) begin
          n_bad++;
          $display("FAIL starve_cnt_full: cnt=%0d at fetch, required %0d", dut.cnt, LIMIT);
        end
      end
      @(negedge clk);
    end
    d_req_valid  = 1'b0;
    if_req_valid = 1'b0;
    wait_idle();
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (acc_log.size() <= a0 + k || acc_log[a0+k] !== ((k % 5) != 4)) begin
        n_bad++;
        $display("FAIL starve_pattern: grant %0d is_data=%0d, required %0d", k,
                 (acc_log.size() > a0 + k) ? int'(acc_log[a0+k]) : -1, int'((k % 5) != 4));
      end
    end
  endtask

  task automatic test_store();
    int d0 = d_pulses;
    int i0 = if_pulses;
    gnt_delay = 3;
    @(negedge clk);
    d_req_valid = 1'b1;
    d_addr      = 16'h0200;
    d_we        = 1'b1;
    d_wdata     = 32'h12345678;
    d_be        = 4'b0011;
    #2;
    n_cmp++;
    if (d_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL store_accept: d_req_ready=%b, required 1", d_req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        d_req_valid = 1'b0;
        d_addr      = 16'hFFFF;
        d_wdata     = '0;
        d_be        = '0;
        d_we        = 1'b0;
      end
      #2;
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b1, 16'h0200, 32'h12345678, 4'b0011}) begin
        n_bad++;
        $display("FAIL store_req_c%0d: got req=%b we=%b addr=%h wdata=%h be=%b, required 1 1 0200 12345678 0011",
                 i + 1, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
      end
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (mem_req !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL store_resp: got mem_req=%b busy=%b, required 0 1", mem_req, busy);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL store_done: got d_rvalid=%b if_rvalid=%b, required 1 0", d_rvalid, if_rvalid);
    end
    gnt_delay = 0;
    wait_idle();
    n_cmp++;
    if (d_pulses != d0 + 1 || if_pulses != i0) begin
      n_bad++;
      $display("FAIL store_pulses: got d=%0d if=%0d, required d=%0d if=%0d", d_pulses, if_pulses, d0 + 1, i0);
    end
  endtask

  task automatic test_spurious();
    int  p0 = if_pulses + d_pulses;
    bit  got = 1'b0;
    @(negedge clk);
    spur_rv_req++;
    @(negedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL spur_idle: got busy=%b mem_req=%b, required 0 0", busy, mem_req);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL spur_idle_after: got if_rvalid=%b d_rvalid=%b busy=%b, required 0 0 0",
               if_rvalid, d_rvalid, busy);
    end
    gnt_delay = 3;
    send_fetch(16'h0050);
    spur_rv_req++;
    #2;
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL spur_req_c1: mem_req=%b, required 1", mem_req);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL spur_req_c2: got mem_req=%b busy=%b, required 1 1", mem_req, busy);
    end
    rsp_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (busy && !mem_req) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL spur_reach_resp: busy=%b mem_req=%b, required RESP within 20 cycles", busy, mem_req);
    end
    spur_gnt_req++;
    repeat (2) begin
      @(negedge clk);
      #2;
      n_cmp++;
      if (mem_req !== 1'b0 || busy !== 1'b1 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL spur_resp: got mem_req=%b busy=%b if_rvalid=%b d_rvalid=%b, required 0 1 0 0",
                 mem_req, busy, if_rvalid, d_rvalid);
      end
    end
    rsp_en    = 1'b1;
    gnt_delay = 0;
    wait_idle();
    n_cmp++;
    if (if_pulses + d_pulses != p0 + 1) begin
      n_bad++;
      $display("FAIL spur_pulses: got %0d pulses, required %0d", if_pulses + d_pulses, p0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    bit got = 1'b0;
    rsp_en = 1'b0;
    send_data(16'h0400, 1'b0, '0, '1);
    for (int i = 0; i < 20; i++) begin
      #2;
      if (busy && !mem_req) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL rstmid_reach_resp: busy=%b mem_req=%b, required RESP", busy, mem_req);
    end
    p0 = if_pulses + d_pulses;
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, mem_req, mem_we, if_rvalid, d_rvalid, if_req_ready, d_req_ready} !== 7'b0 ||
        {mem_addr, mem_wdata, mem_be, if_rdata, d_rdata} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got busy=%b req=%b addr=%h be=%b if_rdata=%h d_rdata=%h, required all 0",
               busy, mem_req, mem_addr, mem_be, if_rdata, d_rdata);
    end
    @(negedge clk);
    rsp_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    n_cmp++;
    if (if_pulses + d_pulses != p0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_no_pulse: got pulses=%0d busy=%b, required %0d 0", if_pulses + d_pulses, busy, p0);
    end
    send_fetch(16'h0010);
    wait_idle();
    n_cmp++;
    if (if_rdata !== 32'hDEADBEEF || if_pulses + d_pulses != p0 + 1) begin
      n_bad++;
      $display("FAIL rstmid_next: got if_rdata=%h pulses=%0d, required deadbeef %0d",
               if_rdata, if_pulses + d_pulses, p0 + 1);
    end
  endtask

  initial begin
    rst          = 1'b0;
    if_req_valid = 1'b0;
    if_addr      = '0;
    d_req_valid  = 1'b0;
    d_addr       = '0;
    d_we         = 1'b0;
    d_wdata      = '0;
    d_be         = '0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
    fork
      responder();
      monitor();
    join_none
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_starvation();
    test_store();
    test_spurious();
    test_reset_mid();
    repeat (2) @(negedge clk);
    #2;
    n_cmp++;
    if (rsp_q.size() != 0 || mem_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: rsp=%0d mem=%0d outstanding, required 0 0", rsp_q.size(), mem_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
